fifo_write_packer: RTL and testbench

- Write-side front end of the interface-unit FIFO, in the write clock domain.
- Accepts a narrow data stream over valid/ready and packs DATA_WIDTH words into FIFO_WIDTH entries.
- Drives winc/waddr/wdata/wfull into the FIFO memory.
- Owns the binary and Gray write pointers. Generates wfull against the read pointer, which arrives already synchronized into wclk.

---
 rtl/fifo_write_packer.sv | 127 ++++++++++++
 tb/tb_fifo_write_packer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_packer.sv
// Write-side packer of the interface FIFO: packs DATA_WIDTH words into FIFO_WIDTH entries and owns the write pointers.
// Define FIFO_WRITE_PACKER_LANE_MASK_EN to add the per-lane wmask output registered alongside wdata.
module fifo_write_packer #(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_WIDTH      = 64,
    parameter int DEPTH           = 16,
    parameter int FIFO_ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             wclk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    input  logic [FIFO_ADDR_WIDTH:0]         wq2_rptr,
    output logic                             winc,
    output logic [FIFO_ADDR_WIDTH-1:0]       waddr,
    output logic [FIFO_WIDTH-1:0]            wdata,
    output logic                             wfull,
`ifdef FIFO_WRITE_PACKER_LANE_MASK_EN
    output logic [FIFO_WIDTH/DATA_WIDTH-1:0] wmask,
`endif
    output logic [FIFO_ADDR_WIDTH:0]         wptr
);
    localparam int PACK   = FIFO_WIDTH / DATA_WIDTH;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
    // A full FIFO shows the read pointer with its two top Gray bits inverted.
    localparam logic [FIFO_ADDR_WIDTH:0] FULL_FLIP =
        (FIFO_ADDR_WIDTH + 1)'(3) << (FIFO_ADDR_WIDTH - 1);

    logic [LANE_W-1:0]          r_lane;
    logic [FIFO_WIDTH-1:0]      r_pack;
    logic [FIFO_WIDTH-1:0]      r_wdata;
    logic                       r_winc;
    logic                       r_wfull;
    logic [FIFO_ADDR_WIDTH:0]   r_wbin;
    logic [FIFO_ADDR_WIDTH:0]   r_wptr;

    logic                       w_accept;
    logic                       w_complete;
    logic                       w_drain;
    logic [FIFO_WIDTH-1:0]      w_merged;
    logic [FIFO_ADDR_WIDTH:0]   w_bin_next;
    logic [FIFO_ADDR_WIDTH:0]   w_gray_next;
    logic                       w_full_next;

    // Ready depends only on registered state, never on the incoming beat.
    assign in_ready   = !(r_winc && r_wfull);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && ((r_lane == LAST_LANE) || in_last);
    assign w_drain    = r_winc && !r_wfull;

    always_comb begin
        w_merged = r_pack;
        for (int i = 0; i < PACK; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_merged[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
        end
    end

    assign w_bin_next  = r_wbin + (FIFO_ADDR_WIDTH + 1)'(w_drain);
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);
    assign w_full_next = (w_gray_next == (wq2_rptr ^ FULL_FLIP));

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            r_lane  <= '0;
            r_pack  <= '0;
            r_wdata <= '0;
            r_winc  <= 1'b0;
            r_wfull <= 1'b0;
            r_wbin  <= '0;
            r_wptr  <= '0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_lane <= '0;
                    r_pack <= '0;
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                    r_pack <= w_merged;
                end
            end
            // A completion in a drain cycle replaces the entry leaving the stage.
            if (w_complete) begin
                r_wdata <= w_merged;
                r_winc  <= 1'b1;
            end else if (w_drain) begin
                r_winc  <= 1'b0;
            end
            r_wbin  <= w_bin_next;
            r_wptr  <= w_gray_next;
            r_wfull <= w_full_next;
        end
    end

`ifdef FIFO_WRITE_PACKER_LANE_MASK_EN
    logic [PACK-1:0] r_wmask;
    logic [PACK-1:0] w_lane_mask;

    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < PACK; i++) begin
            w_lane_mask[i] = (LANE_W'(i) <= r_lane);
        end
    end

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            r_wmask <= '0;
        end else if (w_complete) begin
            r_wmask <= w_lane_mask;
        end
    end

    assign wmask = r_wmask;
`endif

    assign winc  = r_winc;
    assign waddr = r_wbin[FIFO_ADDR_WIDTH-1:0];
    assign wdata = r_wdata;
    assign wfull = r_wfull;
    assign wptr  = r_wptr;

endmodule

// File: tb/tb_fifo_write_packer.sv
// Bench for fifo_write_packer: random beats feed a word-list entry model; a negedge monitor checks every output.
module tb_fifo_write_packer;
    localparam int DW    = 16;
    localparam int FW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PACK  = FW / DW;

    // ---------------- clock / reset ----------------
    logic wclk  = 1'b0;
    logic reset = 1'b1;
    always #5 wclk = ~wclk;

    logic [DW-1:0]   in_data  = '0;
    logic            in_valid = 1'b0;
    logic            in_last  = 1'b0;
    logic            in_ready;
    logic [AW:0]     wq2_rptr;
    logic            winc;
    logic [AW-1:0]   waddr;
    logic [FW-1:0]   wdata;
    logic            wfull;
    logic [AW:0]     wptr;
`ifdef FIFO_WRITE_PACKER_LANE_MASK_EN
    logic [PACK-1:0] wmask;
`endif

    fifo_write_packer #(
        .DATA_WIDTH(DW), .FIFO_WIDTH(FW), .DEPTH(DEPTH), .FIFO_ADDR_WIDTH(AW)
    ) dut (
        .wclk(wclk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .wq2_rptr(wq2_rptr),
        .winc(winc), .waddr(waddr), .wdata(wdata), .wfull(wfull),
`ifdef FIFO_WRITE_PACKER_LANE_MASK_EN
        .wmask(wmask),
`endif
        .wptr(wptr)
    );

    // ---------------- model state ----------------
    logic [FW-1:0]   exp_q[$];
    logic [PACK-1:0] exp_mask_q[$];
    logic [DW-1:0]   cur_words[$];
    int n_vec     = 0;
    int n_err     = 0;
    int n_drained = 0;
    int n_pushed  = 0;
    int rbin      = 0;
    int rbin_edge = 0;
    bit stop_reader = 1'b0;

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] x;
        x = b[AW:0];
        return x ^ (x >> 1);
    endfunction

    assign wq2_rptr = gray(rbin);

    // Read pointer as the DUT saw it at the most recent edge.
    always @(posedge wclk) rbin_edge = rbin;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic last);
        logic [FW-1:0]   e;
        logic [PACK-1:0] m;
        cur_words.push_back(d);
        if (last || cur_words.size() == PACK) begin
            e = '0;
            m = '0;
            foreach (cur_words[k]) begin
                e[k*DW +: DW] = cur_words[k];
                m[k] = 1'b1;
            end
            exp_q.push_back(e);
            exp_mask_q.push_back(m);
            n_pushed++;
            cur_words.delete();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        bit rdy;
        int waited;
        waited   = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        do begin
            @(negedge wclk);
            rdy = in_ready;
            @(posedge wclk);
            #1;
            waited++;
        end while (!rdy && waited < 200);
        check("beat_accepted", FW'(rdy), FW'(1));
        if (rdy) model_accept(d, last);
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = DW'($urandom);
    endtask

    task automatic send_entry_full();
        for (int k = 0; k < PACK; k++) send_beat(DW'($urandom), 1'b0);
    endtask

    task automatic wait_drained(input int target, input int budget);
        int c;
        c = 0;
        while (n_drained < target && c < budget) begin
            @(posedge wclk);
            #1;
            c++;
        end
        check("drained_count", FW'(n_drained), FW'(target));
    endtask

    task automatic reset_check(input string tag);
        @(negedge wclk);
        #2;
        reset = 1'b1;
        rbin  = 0;
        #1;
        check({tag, "_in_ready"}, FW'(in_ready), FW'(1));
        check({tag, "_winc"},     FW'(winc),     FW'(0));
        check({tag, "_waddr"},    FW'(waddr),    FW'(0));
        check({tag, "_wdata"},    wdata,         FW'(0));
        check({tag, "_wfull"},    FW'(wfull),    FW'(0));
        check({tag, "_wptr"},     FW'(wptr),     FW'(0));
`ifdef FIFO_WRITE_PACKER_LANE_MASK_EN
        check({tag, "_wmask"},    FW'(wmask),    FW'(0));
`endif
        exp_q.delete();
        exp_mask_q.delete();
        cur_words.delete();
        n_drained = 0;
        n_pushed  = 0;
        @(posedge wclk);
        @(posedge wclk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        bit              staged;
        bit              full_m;
        logic [FW-1:0]   e;
        logic [PACK-1:0] m;
        forever begin
            @(negedge wclk);
            if (!reset) begin
                staged = (exp_q.size() != 0);
                full_m = (((n_drained - rbin_edge) & (2*DEPTH - 1)) == DEPTH);
                check("winc",     FW'(winc),     FW'(staged));
                check("wfull",    FW'(wfull),    FW'(full_m));
                check("in_ready", FW'(in_ready), FW'(!(staged && full_m)));
                check("waddr",    FW'(waddr),    FW'(n_drained % DEPTH));
                check("wptr",     FW'(wptr),     FW'(gray(n_drained)));
                if (staged && !full_m) begin
                    e = exp_q.pop_front();
                    m = exp_mask_q.pop_front();
                    check("wdata", wdata, e);
`ifdef FIFO_WRITE_PACKER_LANE_MASK_EN
                    check("wmask", FW'(wmask), FW'(m));
`endif
                    n_drained++;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int len;
        bit lst;
        repeat (3) @(posedge wclk);
        #1;
        check("rst_in_ready", FW'(in_ready), FW'(1));
        check("rst_winc",     FW'(winc),     FW'(0));
        check("rst_wdata",    wdata,         FW'(0));
        check("rst_wptr",     FW'(wptr),     FW'(0));
        reset = 1'b0;
        idle(2);

        // Basic full entry
        send_beat(16'h0001, 1'b0);
        send_beat(16'h0002, 1'b0);
        send_beat(16'h0003, 1'b0);
        send_beat(16'h0004, 1'b0);
        @(negedge wclk);
        check("t1_wdata", wdata, 64'h0004_0003_0002_0001);
        check("t1_winc",  FW'(winc),  FW'(1));
        check("t1_waddr", FW'(waddr), FW'(0));
        @(posedge wclk);
        #1;
        check("t1_wptr_after",  FW'(wptr),  FW'(1));
        check("t1_waddr_after", FW'(waddr), FW'(1));
        idle(2);

        // Partial flush
        send_beat(16'hAAAA, 1'b0);
        send_beat(16'hBBBB, 1'b1);
        @(negedge wclk);
        check("t2_wdata", wdata, 64'h0000_0000_BBBB_AAAA);
`ifdef FIFO_WRITE_PACKER_LANE_MASK_EN
        check("t2_wmask", FW'(wmask), FW'(4'b0011));
`endif
        idle(2);

        // Single-word entry
        send_beat(16'h5A5A, 1'b1);
        @(negedge wclk);
        check("t2b_wdata", wdata, 64'h0000_0000_0000_5A5A);
        idle(2);

        // Fill to full with the read pointer parked at 0
        reset_check("rst_a");
        for (int e = 0; e < DEPTH; e++) send_entry_full();
        idle(3);
        check("t3_wfull",    FW'(wfull),    FW'(1));
        check("t3_wptr",     FW'(wptr),     FW'(5'b11000));
        check("t3_in_ready", FW'(in_ready), FW'(1));
        send_entry_full();
        idle(3);
        check("t3_staged_winc",  FW'(winc),     FW'(1));
        check("t3_staged_ready", FW'(in_ready), FW'(0));
        check("t3_staged_waddr", FW'(waddr),    FW'(0));
        rbin = 1;
        wait_drained(DEPTH + 1, 20);
        idle(1);
        check("t3_ready_back", FW'(in_ready), FW'(1));

        // Two lanes filled while full, then reset discards them
        send_beat(16'hDEAD, 1'b0);
        send_beat(16'hBEEF, 1'b0);
        reset_check("rst_b");
        send_beat(16'h1111, 1'b0);
        send_beat(16'h2222, 1'b0);
        send_beat(16'h3333, 1'b0);
        send_beat(16'h4444, 1'b0);
        @(negedge wclk);
        check("t5_wdata", wdata, 64'h4444_3333_2222_1111);
        check("t5_waddr", FW'(waddr), FW'(0));
        idle(2);

        // Streaming with a tracking reader, random lengths and gaps
        stop_reader = 1'b0;
        fork
            begin
                while (!stop_reader) begin
                    @(posedge wclk);
                    #1;
                    if ((n_drained - rbin) > 0 && $urandom_range(0, 3) != 0) rbin++;
                end
            end
        join_none
        for (int e = 0; e < 40; e++) begin
            len = $urandom_range(1, PACK);
            for (int k = 0; k < len; k++) begin
                lst = (k == len - 1) ? ((len < PACK) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                send_beat(DW'($urandom), lst);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        wait_drained(n_pushed, 300);
        stop_reader = 1'b1;
        idle(2);
        check("t4_queue_empty", FW'(exp_q.size()), FW'(0));
        check("t4_no_partial",  FW'(cur_words.size()), FW'(0));

        // Reset while an entry is staged against a full FIFO
        reset_check("rst_c");
        for (int e = 0; e < DEPTH + 1; e++) send_entry_full();
        idle(3);
        check("t6_staged_winc",  FW'(winc),     FW'(1));
        check("t6_staged_ready", FW'(in_ready), FW'(0));
        reset_check("rst_d");
        idle(3);
        check("t6_ready_after", FW'(in_ready), FW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
